hazard_control: RTL and testbench
=================================

Name: hazard_control

Overview:
- Producer-side counterpart of the pipeline forwarding unit. It decides when a dependency cannot be bypassed, and which pipeline registers must freeze, bubble or flush.
- Sits beside the 5-stage RISC-V datapath and drives the PC, IF/ID and ID/EX register controls.
- Handles three events: load-use stall, taken-branch flush, and data-memory wait.
- Keeps saturating stall and flush counters for the merge-sort benchmark.

Parameters:
- CNT_W, 32, width of the stall and flush performance counters.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; all state cleared on the rising edge of clk while reset=1
- rs1ID  in  REG_AW  rs1 of the instruction in ID
- rs2ID  in  REG_AW  rs2 of the instruction in ID
- useRs1ID  in  1  ID instruction reads rs1
- useRs2ID  in  1  ID instruction reads rs2
- rdEX  in  REG_AW  destination of the instruction in EX
- EscRegEX  in  1  register write enable of EX, active-low (0 = writes)
- lwEX  in  1  EX instruction is a load
- branchTakenEX  in  1  branch or jump resolved taken in EX
- memBusy  in  1  data memory not ready this cycle
- pcWrite  out  1  PC may update
- ifidWrite  out  1  IF/ID may load
- ifidFlush  out  1  IF/ID loaded with a NOP
- idexBubble  out  1  ID/EX loaded with a NOP
- exmemWrite  out  1  EX/MEM and MEM/WB may load
- stallCount  out  CNT_W  cycles lost to load-use and memory wait
- flushCount  out  CNT_W  taken-branch flushes

Behaviour:
- Reset values: pcWrite=1, ifidWrite=1, ifidFlush=0, idexBubble=0, exmemWrite=1, stallCount=0, flushCount=0, state=RUN, flushPend=0.
- loadUse (combinational) = lwEX & !EscRegEX & (rdEX!=0) & ((useRs1ID & rs1ID==rdEX) | (useRs2ID & rs2ID==rdEX)).
- Control outputs are combinational from the state and the inputs; the state, flushPend and the counters are registered.
- FSM states: RUN, LOAD_STALL, MEM_WAIT.
- Priority within a cycle, highest first: memBusy, then a taken branch or flushPend, then loadUse.
- memBusy=1 (any state):
  - All write enables are 0 (pcWrite, ifidWrite, exmemWrite); ifidFlush=0; idexBubble=0.
  - Next state is MEM_WAIT and stallCount increments.
  - If branchTakenEX=1 in the same cycle, set flushPend=1. The flush is deferred, never lost.
- MEM_WAIT with memBusy=0: go to RUN. Controls in this cycle are evaluated as for RUN.
- RUN, branchTakenEX or flushPend, memBusy=0:
  - ifidFlush=1, idexBubble=1, pcWrite=1 (PC takes the target), ifidWrite=1.
  - flushCount increments and flushPend clears.
  - A coincident loadUse is ignored because the consumer is being flushed.
- RUN, loadUse, no branch, memBusy=0:
  - pcWrite=0, ifidWrite=0, idexBubble=1, exmemWrite=1.
  - stallCount increments; next state is LOAD_STALL.
- LOAD_STALL:
  - Exactly one stall cycle has been spent. The load is now in MEM, and the consumer obtains the value by WB forwarding next cycle.
  - Outputs are the normal RUN values; next state is RUN.
  - loadUse is not re-evaluated in this cycle; the bubble already sits in EX.
- Counters saturate at all-ones and never wrap.
- Reset mid-stall or mid-wait returns the block to RUN immediately, with flushPend=0 and the counters at 0.
- A load writing x0 never stalls, and EscRegEX=1 never stalls.

Decomposition:
- Package hazard_pkg: the state enum (RUN, LOAD_STALL, MEM_WAIT), the REG_AW default, and the NOP encoding constant shared with the pipeline registers.
- One sub-module, sat_counter (width parameter, enable, synchronous reset), instantiated twice.

Test Plan:
- Load-use on rs1: lw x5 in EX, ID reads x5 (useRs1ID=1) -> one cycle with pcWrite=0, ifidWrite=0, idexBubble=1. Next cycle RUN outputs, and stallCount=1.
- Load to x0, or EscRegEX=1 with matching rs -> no stall; pcWrite stays 1.
- Taken branch together with loadUse -> ifidFlush=1, idexBubble=1, pcWrite=1, no stall; flushCount=1, stallCount=0.
- memBusy high for 3 cycles with branchTakenEX pulsed in the first -> 3 frozen cycles with all enables 0. On the cycle memBusy drops, ifidFlush=1 and idexBubble=1. Final stallCount=3, flushCount=1.
- Reset asserted during LOAD_STALL -> next cycle all outputs at reset values and state=RUN.
- Counter saturation (CNT_W=4): 20 consecutive memBusy cycles -> stallCount holds at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

    // Default register-file address width of the datapath
    localparam int REG_AW_DEF = 5;

    // Canonical NOP (addi x0, x0, 0) that the pipeline registers load on a flush or bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Hazard controller FSM states
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         at_max;

    assign at_max = &count_q;

    // Hold at all-ones so a long run never wraps back to a small value
    always_comb begin
        count_d = count_q;
        if (en_i && !at_max) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register, cleared synchronously
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_control.sv
// rtl/hazard_control.sv - load-use stall, branch flush and memory-wait control for a 5-stage pipeline
module hazard_control
    import hazard_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1ID,
    input  logic [REG_AW-1:0] rs2ID,
    input  logic              useRs1ID,
    input  logic              useRs2ID,
    input  logic [REG_AW-1:0] rdEX,
    input  logic              EscRegEX,
    input  logic              lwEX,
    input  logic              branchTakenEX,
    input  logic              memBusy,
    output logic              pcWrite,
    output logic              ifidWrite,
    output logic              ifidFlush,
    output logic              idexBubble,
    output logic              exmemWrite,
    output logic [CNT_W-1:0]  stallCount,
    output logic [CNT_W-1:0]  flushCount
);

    hz_state_e state_q;
    hz_state_e state_d;
    logic      flush_pend_q;
    logic      flush_pend_d;
    logic      stall_inc;
    logic      flush_inc;
    logic      load_use;
    logic      flush_now;

    // EscRegEX is active-low; a load targeting x0 never produces a value worth waiting for
    assign load_use = lwEX && !EscRegEX && (rdEX != '0) &&
                      ((useRs1ID && (rs1ID == rdEX)) || (useRs2ID && (rs2ID == rdEX)));

    // A flush deferred by a memory wait is replayed as soon as the memory is ready
    assign flush_now = branchTakenEX || flush_pend_q;

    // Next state and pipeline controls; memory wait outranks flush, flush outranks load-use
    always_comb begin
        pcWrite      = 1'b1;
        ifidWrite    = 1'b1;
        ifidFlush    = 1'b0;
        idexBubble   = 1'b0;
        exmemWrite   = 1'b1;
        state_d      = RUN;
        flush_pend_d = flush_pend_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (memBusy) begin
            // Freeze the whole pipeline; remember any branch so it is not lost
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            exmemWrite = 1'b0;
            state_d    = MEM_WAIT;
            stall_inc  = 1'b1;
            if (branchTakenEX) begin
                flush_pend_d = 1'b1;
            end
        end else if (flush_now) begin
            // Wrong-path instructions in IF/ID and ID/EX are discarded; PC takes the target
            ifidFlush    = 1'b1;
            idexBubble   = 1'b1;
            flush_inc    = 1'b1;
            flush_pend_d = 1'b0;
        end else if (load_use && (state_q != LOAD_STALL)) begin
            // One bubble lets the load reach MEM so WB forwarding can supply the consumer
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
            stall_inc  = 1'b1;
            state_d    = LOAD_STALL;
        end
    end

    // FSM state and pending-flush registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (stall_inc),
        .count_o (stallCount)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (flush_inc),
        .count_o (flushCount)
    );

endmodule

// File: tb/tb_hazard_control.sv
// tb/tb_hazard_control.sv - directed scoreboard bench for hazard_control
module tb_hazard_control;

    logic       clk;
    logic       reset;
    logic [4:0] rs1ID, rs2ID, rdEX;
    logic       useRs1ID, useRs2ID, EscRegEX, lwEX, branchTakenEX, memBusy;

    logic        pcWrite, ifidWrite, ifidFlush, idexBubble, exmemWrite;
    logic [31:0] stallCount, flushCount;

    logic        pcWrite4, ifidWrite4, ifidFlush4, idexBubble4, exmemWrite4;
    logic [3:0]  stallCount4, flushCount4;

    typedef struct {
        string      tag;
        logic [4:0] ctl;
        int         sc;
        int         fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert;
    int   n_fail;

    localparam logic [4:0] C_RUN   = 5'b11001;
    localparam logic [4:0] C_STALL = 5'b00011;
    localparam logic [4:0] C_FLUSH = 5'b11111;
    localparam logic [4:0] C_FREEZE = 5'b00000;

    hazard_control dut (
        .clk           (clk),
        .reset         (reset),
        .rs1ID         (rs1ID),
        .rs2ID         (rs2ID),
        .useRs1ID      (useRs1ID),
        .useRs2ID      (useRs2ID),
        .rdEX          (rdEX),
        .EscRegEX      (EscRegEX),
        .lwEX          (lwEX),
        .branchTakenEX (branchTakenEX),
        .memBusy       (memBusy),
        .pcWrite       (pcWrite),
        .ifidWrite     (ifidWrite),
        .ifidFlush     (ifidFlush),
        .idexBubble    (idexBubble),
        .exmemWrite    (exmemWrite),
        .stallCount    (stallCount),
        .flushCount    (flushCount)
    );

    hazard_control #(.CNT_W(4)) dut4 (
        .clk           (clk),
        .reset         (reset),
        .rs1ID         (rs1ID),
        .rs2ID         (rs2ID),
        .useRs1ID      (useRs1ID),
        .useRs2ID      (useRs2ID),
        .rdEX          (rdEX),
        .EscRegEX      (EscRegEX),
        .lwEX          (lwEX),
        .branchTakenEX (branchTakenEX),
        .memBusy       (memBusy),
        .pcWrite       (pcWrite4),
        .ifidWrite     (ifidWrite4),
        .ifidFlush     (ifidFlush4),
        .idexBubble    (idexBubble4),
        .exmemWrite    (exmemWrite4),
        .stallCount    (stallCount4),
        .flushCount    (flushCount4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, queue the expected response, then compare at the falling edge
    task automatic step(input string tag, input logic rst,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic esc, input logic lw,
                        input logic br, input logic mb,
                        input logic [4:0] ctl, input int sc, input int fc);
        exp_t e;
        exp_t got;
        reset = rst;
        rs1ID = rs1; useRs1ID = u1;
        rs2ID = rs2; useRs2ID = u2;
        rdEX = rd; EscRegEX = esc; lwEX = lw;
        branchTakenEX = br; memBusy = mb;
        e.tag = tag; e.ctl = ctl; e.sc = sc; e.fc = fc;
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        check({got.tag, "_ctl"}, {27'd0, pcWrite, ifidWrite, ifidFlush, idexBubble, exmemWrite},
              {27'd0, got.ctl});
        check({got.tag, "_stall"}, stallCount, got.sc);
        check({got.tag, "_flush"}, flushCount, got.fc);
        check({got.tag, "_stall4"}, {28'd0, stallCount4}, (got.sc > 15) ? 32'd15 : got.sc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [4:0] ctl, input int sc, input int fc);
        step(tag, 1'b0, 5'd1, 1'b0, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, ctl, sc, fc);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset = 1'b1;
        rs1ID = 5'd1; rs2ID = 5'd2; rdEX = 5'd0;
        useRs1ID = 1'b0; useRs2ID = 1'b0; EscRegEX = 1'b1; lwEX = 1'b0;
        branchTakenEX = 1'b0; memBusy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        idle("reset_state", C_RUN, 0, 0);

        // load-use on rs1, then the LOAD_STALL cycle with the hazard inputs still present
        step("lu_rs1", 0, 5'd5, 1, 5'd2, 0, 5'd5, 0, 1, 0, 0, C_STALL, 0, 0);
        step("lu_hold", 0, 5'd5, 1, 5'd2, 0, 5'd5, 0, 1, 0, 0, C_RUN, 1, 0);
        idle("run_after_lu", C_RUN, 1, 0);

        // load-use on rs2
        step("lu_rs2", 0, 5'd3, 1, 5'd7, 1, 5'd7, 0, 1, 0, 0, C_STALL, 1, 0);
        idle("run_after_rs2", C_RUN, 2, 0);

        // non-stalling lookalikes
        step("load_x0", 0, 5'd0, 1, 5'd0, 1, 5'd0, 0, 1, 0, 0, C_RUN, 2, 0);
        step("esc_high", 0, 5'd5, 1, 5'd2, 0, 5'd5, 1, 1, 0, 0, C_RUN, 2, 0);
        step("rs_unused", 0, 5'd5, 0, 5'd5, 0, 5'd5, 0, 1, 0, 0, C_RUN, 2, 0);
        step("not_load", 0, 5'd5, 1, 5'd2, 0, 5'd5, 0, 0, 0, 0, C_RUN, 2, 0);

        // taken branch overrides a coincident load-use
        step("br_lu", 0, 5'd5, 1, 5'd2, 0, 5'd5, 0, 1, 1, 0, C_FLUSH, 2, 0);
        idle("after_br", C_RUN, 2, 1);

        // reset during LOAD_STALL
        step("lu_pre_rst", 0, 5'd6, 1, 5'd2, 0, 5'd6, 0, 1, 0, 0, C_STALL, 2, 1);
        step("rst_in_stall", 1, 5'd1, 0, 5'd2, 0, 5'd0, 1, 0, 0, 0, C_RUN, 3, 1);
        idle("post_rst", C_RUN, 0, 0);
        step("lu_post_rst", 0, 5'd6, 1, 5'd2, 0, 5'd6, 0, 1, 0, 0, C_STALL, 0, 0);
        idle("run_post_rst", C_RUN, 1, 0);

        // memory wait with a branch in its first cycle: the flush is replayed afterwards
        step("mb_br", 0, 5'd1, 0, 5'd2, 0, 5'd0, 1, 0, 1, 1, C_FREEZE, 1, 0);
        step("mb_2", 0, 5'd1, 0, 5'd2, 0, 5'd0, 1, 0, 0, 1, C_FREEZE, 2, 0);
        step("mb_3", 0, 5'd1, 0, 5'd2, 0, 5'd0, 1, 0, 0, 1, C_FREEZE, 3, 0);
        idle("mb_release", C_FLUSH, 4, 0);
        idle("mb_after", C_RUN, 4, 1);
        idle("pend_clear", C_RUN, 4, 1);

        // load-use hidden behind a memory wait is honoured once memory is ready
        step("mb_lu", 0, 5'd9, 1, 5'd2, 0, 5'd9, 0, 1, 0, 1, C_FREEZE, 4, 1);
        step("mw_lu", 0, 5'd9, 1, 5'd2, 0, 5'd9, 0, 1, 0, 0, C_STALL, 5, 1);
        idle("mw_lu_done", C_RUN, 6, 1);

        // saturation of the 4-bit instance
        step("sat_rst", 1, 5'd1, 0, 5'd2, 0, 5'd0, 1, 0, 0, 0, C_RUN, 6, 1);
        for (int i = 0; i < 20; i++) begin
            step($sformatf("sat_%0d", i), 0, 5'd1, 0, 5'd2, 0, 5'd0, 1, 0, 0, 1,
                 C_FREEZE, i, 0);
        end
        idle("sat_final", C_RUN, 20, 0);

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
